// File: rtl/mmio_bus_ctrl.sv
// ============================================================================
//  Module      : mmio_bus_ctrl
//  Description : Memory-mapped bus controller: RAM / LED / switch / timer decode
//                with a registered read path for single-cycle read latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_bus_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int LED_W    = 10,
    parameter int SW_W     = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       DOUT,
    input  logic              W,
    output logic [15:0]       DIN,
    input  logic [15:0]       mem_q,
    output logic              mem_wren,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LEDR,
    output logic              timer_irq
);

    localparam logic [3:0]  PAGE_RAM   = 4'h0;
    localparam logic [3:0]  PAGE_LED   = 4'h1;
    localparam logic [3:0]  PAGE_SW    = 4'h3;
    localparam logic [3:0]  PAGE_TMR   = 4'h4;

    localparam logic [1:0]  TMR_LOAD   = 2'd0;
    localparam logic [1:0]  TMR_CTRL   = 2'd1;
    localparam logic [1:0]  TMR_COUNT  = 2'd2;
    localparam logic [1:0]  TMR_STATUS = 2'd3;

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [3:0]        page;
    logic              sel_ram;
    logic              sel_led;
    logic              sel_tmr;
    logic              wr_led;
    logic              wr_load;
    logic              wr_ctrl;
    logic              wr_status;

    logic [LED_W-1:0]  led_reg;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;

    logic [15:0]       load_reg;
    logic [15:0]       count;
    logic [15:0]       presc;
    logic              en;
    logic              auto_rl;
    logic              expired;
    logic              tick;
    logic              expire;

    logic [3:0]        rd_sel;
    logic [15:0]       periph_q;
    logic [15:0]       periph_next;
    logic              unused_bits;

    // ------------------------------------------------------------------
    // Address decode and write strobes
    // ------------------------------------------------------------------
    assign page      = ADDR[15:12];
    assign sel_ram   = (page == PAGE_RAM);
    assign sel_led   = (page == PAGE_LED);
    assign sel_tmr   = (page == PAGE_TMR);

    assign mem_wren  = W & sel_ram;
    assign wr_led    = W & sel_led;
    assign wr_load   = W & sel_tmr & (ADDR[1:0] == TMR_LOAD);
    assign wr_ctrl   = W & sel_tmr & (ADDR[1:0] == TMR_CTRL);
    assign wr_status = W & sel_tmr & (ADDR[1:0] == TMR_STATUS);

    assign unused_bits = ^ADDR[11:2];

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            led_reg <= '0;
        end else if (wr_led) begin
            led_reg <= DOUT[LED_W-1:0];
        end
    end

    assign LEDR = led_reg;

    // ------------------------------------------------------------------
    // Switch synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Timer: prescaler, down-counter, control and status
    // ------------------------------------------------------------------
    assign tick   = en && (presc == PRESCALE_MAX);
    // A LOAD write on the tick edge takes priority, so it also suppresses expiry.
    assign expire = tick && (count == 16'd1) && !wr_load;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
        end else if (wr_load || (wr_ctrl && !DOUT[0]) || !en || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            load_reg <= '0;
            count    <= '0;
        end else if (wr_load) begin
            load_reg <= DOUT;
            count    <= DOUT;
        end else if (tick) begin
            if (count > 16'd1) begin
                count <= count - 16'd1;
            end else if (count == 16'd1) begin
                count <= auto_rl ? load_reg : 16'd0;
            end
        end
    end

    // A CTRL write on the same edge as a one-shot expiry overrides the auto-clear.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
        end else if (wr_ctrl) begin
            en      <= DOUT[0];
            auto_rl <= DOUT[1];
        end else if (expire && !auto_rl) begin
            en      <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (wr_status && DOUT[0]) begin
            expired <= 1'b0;
        end
    end

    assign timer_irq = expired;

    // ------------------------------------------------------------------
    // Registered read path
    // ------------------------------------------------------------------
    always_comb begin
        periph_next = 16'h0000;
        case (page)
            PAGE_LED: periph_next = 16'(led_reg);
            PAGE_SW:  periph_next = 16'(sw_sync);
            PAGE_TMR: begin
                case (ADDR[1:0])
                    TMR_LOAD:   periph_next = load_reg;
                    TMR_CTRL:   periph_next = {14'd0, auto_rl, en};
                    TMR_COUNT:  periph_next = count;
                    TMR_STATUS: periph_next = {15'd0, expired};
                    default:    periph_next = 16'h0000;
                endcase
            end
            default:  periph_next = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_sel   <= '0;
            periph_q <= '0;
        end else begin
            rd_sel   <= page;
            periph_q <= periph_next;
        end
    end

    // RAM data already carries its one-cycle latency from the external memory.
    assign DIN = (rd_sel == PAGE_RAM) ? mem_q : periph_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
// ============================================================================
//  Module      : tb_mmio_bus_ctrl
//  Description : Scoreboard bench for mmio_bus_ctrl (PRESCALE=4 and PRESCALE=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_bus_ctrl;

    localparam int K_DIN4 = 0;
    localparam int K_DIN2 = 1;
    localparam int K_LED  = 2;
    localparam int K_IRQ4 = 3;
    localparam int K_IRQ2 = 4;
    localparam int K_WREN = 5;

    typedef struct {
        int          kind;
        int          due;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] mem_q;
    logic [9:0]  SW;

    logic [15:0] din4, din2;
    logic        wren4, wren2;
    logic [9:0]  led4, led2;
    logic        irq4, irq2;

    exp_t sbq[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] t3_din [1:13];
    logic [15:0] t4_din [1:13];
    logic [15:0] t4_irq [1:13];

    mmio_bus_ctrl #(.PRESCALE(4), .LED_W(10), .SW_W(10)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .DIN(din4), .mem_q(mem_q), .mem_wren(wren4), .SW(SW), .LEDR(led4),
        .timer_irq(irq4)
    );

    mmio_bus_ctrl #(.PRESCALE(2), .LED_W(10), .SW_W(10)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .DIN(din2), .mem_q(mem_q), .mem_wren(wren2), .SW(SW), .LEDR(led2),
        .timer_irq(irq2)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [15:0] sample(input int k);
        case (k)
            K_DIN4:  return din4;
            K_DIN2:  return din2;
            K_LED:   return {6'd0, led4};
            K_IRQ4:  return {15'd0, irq4};
            K_IRQ2:  return {15'd0, irq2};
            K_WREN:  return {15'd0, wren4};
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compares every queued expectation that falls due this cycle.
    always @(negedge Clock) begin : monitor
        int          i;
        logic [15:0] act;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                act   = sample(sbq[i].kind);
                total = total + 1;
                if (act !== sbq[i].exp) begin
                    bad = bad + 1;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             sbq[i].name, act, sbq[i].exp, cyc);
                end
                sbq.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
        ADDR = a;
        DOUT = d;
        W    = w;
    endtask

    task automatic want(input int k, input int lat, input logic [15:0] e, input string nm);
        exp_t x;
        x.kind = k;
        x.due  = cyc + lat;
        x.exp  = e;
        x.name = nm;
        sbq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        t3_din = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd2, 16'd2, 16'd2, 16'd2,
                   16'd1, 16'd1, 16'd1, 16'd1, 16'd0};
        t4_din = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd1, 16'd1, 16'd1,
                   16'd2, 16'd2, 16'd1, 16'd1, 16'd1};
        t4_irq = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1,
                   16'd1, 16'd1, 16'd1, 16'd1, 16'd0};

        Resetn = 1'b0;
        ADDR   = 16'h1000;
        DOUT   = 16'hFFFF;
        W      = 1'b1;
        mem_q  = 16'h1234;
        SW     = 10'h000;

        // T1: reset held with write strobe toggling
        repeat (3) begin
            step();
            want(K_LED,  0, 16'h0000, "t1_led_in_reset");
            want(K_IRQ4, 0, 16'h0000, "t1_irq_in_reset");
            want(K_DIN4, 0, 16'h1234, "t1_din_is_memq");
            W = ~W;
        end
        Resetn = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0);
        want(K_LED, 1, 16'h0000, "t1_led_after_release");
        step();

        // T2: LED write/readback, switch synchronizer, unmapped read
        drive(16'h1000, 16'h02A5, 1'b1);
        want(K_LED, 1, 16'h02A5, "t2_led_write");
        step();
        drive(16'h1000, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h02A5, "t2_led_readback");
        step();
        SW = 10'h155;
        drive(16'h0000, 16'h0000, 1'b0);
        repeat (3) step();
        drive(16'h3000, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0155, "t2_sw_read");
        step();
        drive(16'h7000, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0000, "t2_unmapped_read");
        step();

        // T3: one-shot on PRESCALE=4
        drive(16'h4000, 16'd3, 1'b1);
        step();
        drive(16'h4001, 16'h0001, 1'b1);
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            want(K_DIN4, 1, t3_din[k], "t3_count");
            want(K_IRQ4, 1, (k >= 12) ? 16'd1 : 16'd0, "t3_irq");
            step();
        end
        drive(16'h4003, 16'h0000, 1'b1);
        want(K_IRQ4, 1, 16'h0001, "t3_status_w0_no_clear");
        step();
        drive(16'h4001, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0000, "t3_en_cleared");
        step();
        drive(16'h4003, 16'h0001, 1'b1);
        want(K_IRQ4, 1, 16'h0000, "t3_status_w1c");
        step();

        // T4: auto-reload on PRESCALE=2, W1C on expiry edge
        drive(16'h4000, 16'd2, 1'b1);
        step();
        drive(16'h4001, 16'h0003, 1'b1);
        step();
        for (int k = 1; k <= 13; k++) begin
            if (k == 6 || k == 12 || k == 13) drive(16'h4003, 16'h0001, 1'b1);
            else                              drive(16'h4002, 16'h0000, 1'b0);
            want(K_DIN2, 1, t4_din[k], "t4_read");
            want(K_IRQ2, 1, t4_irq[k], "t4_irq");
            step();
        end
        drive(16'h4001, 16'h0000, 1'b1);
        step();
        drive(16'h4003, 16'h0001, 1'b1);
        step();

        // T5: LOAD write on tick edge, then LOAD=0 with EN=1
        drive(16'h4000, 16'd1, 1'b1);
        step();
        drive(16'h4001, 16'h0001, 1'b1);
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        repeat (3) step();
        drive(16'h4000, 16'd5, 1'b1);
        want(K_IRQ4, 1, 16'h0000, "t5_collide_irq");
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'd5, "t5_load_wins");
        want(K_IRQ4, 1, 16'h0000, "t5_no_expiry");
        step();
        repeat (2) step();
        want(K_DIN4, 1, 16'd5, "t5_prescaler_restarted");
        step();
        want(K_DIN4, 1, 16'd4, "t5_next_tick");
        step();
        drive(16'h4000, 16'd0, 1'b1);
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        repeat (20) step();
        want(K_DIN4, 1, 16'd0, "t5_zero_count");
        want(K_IRQ4, 1, 16'h0000, "t5_zero_never");
        step();
        drive(16'h4001, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0001, "t5_en_kept");
        step();
        drive(16'h4001, 16'h0000, 1'b1);
        step();

        // T6: RAM path and reset mid-count
        drive(16'h0042, 16'hAAAA, 1'b1);
        want(K_WREN, 0, 16'h0001, "t6_wren_ram");
        step();
        drive(16'h1000, 16'h0003, 1'b1);
        want(K_WREN, 0, 16'h0000, "t6_wren_led");
        want(K_LED,  1, 16'h0003, "t6_led_write");
        step();
        mem_q = 16'hBEEF;
        drive(16'h0042, 16'h0000, 1'b0);
        want(K_WREN, 0, 16'h0000, "t6_wren_read");
        want(K_DIN4, 1, 16'hBEEF, "t6_ram_read");
        step();
        drive(16'h4000, 16'd7, 1'b1);
        step();
        drive(16'h4001, 16'h0001, 1'b1);
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        repeat (5) step();
        Resetn = 1'b0;
        #2;
        Resetn = 1'b1;
        want(K_LED,  0, 16'h0000, "t6_reset_led");
        want(K_IRQ4, 0, 16'h0000, "t6_reset_irq");
        want(K_DIN4, 0, 16'hBEEF, "t6_reset_din");
        drive(16'h4001, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0000, "t6_ctrl_cleared");
        step();
        drive(16'h4002, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0000, "t6_count_cleared");
        step();
        drive(16'h4000, 16'h0000, 1'b0);
        want(K_DIN4, 1, 16'h0000, "t6_load_cleared");
        step();

        repeat (2) step();
        if (sbq.size() != 0) begin
            $display("FAIL unchecked: got %0d pending expected 0", sbq.size());
            total = total + sbq.size();
            bad   = bad + sbq.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
